mult_datapath: RTL and testbench
================================

MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning operand width in bits; legal range 2..32.
REQ-002 The module SHALL have port Clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, meaning reset that is synchronous and active-low.
REQ-004 The module SHALL have port Load, input, 1 bit, meaning load operands and clear the bit counter.
REQ-005 The module SHALL have port Ad, input, 1 bit, meaning add multiplicand into the upper accumulator half.
REQ-006 The module SHALL have port Sh, input, 1 bit, meaning shift the accumulator right one bit and advance the counter.
REQ-007 The module SHALL have port Mcand, input, N bits, meaning the multiplicand (unsigned).
REQ-008 The module SHALL have port Mplier, input, N bits, meaning the multiplier (unsigned).
REQ-009 The module SHALL have port M, output, 1 bit, meaning the current multiplier LSB, ACC[0], combinational from state.
REQ-010 The module SHALL have port K, output, 1 bit, meaning the last shift is pending: high iff counter == N-1, combinational from state.
REQ-011 The module SHALL have port Product, output, 2N bits, meaning ACC[2N-1:0].

Function
REQ-012 The accumulator ACC SHALL be 2N+1 bits; bit 2N holds the add carry.
REQ-013 The shift counter SHALL be clog2(N) bits wide and unsigned.
REQ-014 Load SHALL act as follows at the clock edge: ACC <= {(N+1)'b0, Mplier}; counter <= 0.
REQ-015 Ad alone SHALL act as follows at the clock edge: ACC[2N:N] <= {1'b0, ACC[2N-1:N]} + {1'b0, Mcand_eff}; ACC[N-1:0] and the counter hold.
REQ-016 Sh alone SHALL act as follows at the clock edge: ACC <= {1'b0, ACC[2N:1]}; counter <= counter+1.
REQ-017 Ad and Sh together SHALL perform the add, then shift the sum in the same cycle, and SHALL advance the counter.
REQ-018 Priority SHALL be Load over Ad/Sh; Ad or Sh asserted with Load SHALL be ignored.
REQ-019 With no command asserted, all state SHALL hold.
REQ-020 A Sh at counter == N-1 SHALL wrap the counter to 0; K SHALL then drop in the following cycle.
REQ-021 Any further Sh after completion SHALL still shift ACC; no saturation or lockout applies.
REQ-022 Latency SHALL be one cycle per command; Product is valid the cycle after the N-th Sh.
REQ-023 M and K SHALL have no combinational path from Load, Ad, Sh, Mcand, or Mplier.

Reset
REQ-024 rst == 0 at a rising Clk edge SHALL clear ACC, the counter and any latched multiplicand, overriding every command, including mid-operation.
REQ-025 The first cycle after reset SHALL present Product = 0, M = 0 and K = 0.

Configuration
REQ-026 With MULT_LATCH_MCAND_EN defined, Mcand SHALL be captured into an internal N-bit register on Load, and Mcand_eff SHALL be that register; later Mcand changes SHALL have no effect until the next Load.
REQ-027 Without MULT_LATCH_MCAND_EN, Mcand_eff SHALL be the live Mcand port, and no multiplicand register SHALL exist.

Structure
REQ-028 Package mult_pkg SHALL hold: the default width constant MULT_N_DEFAULT = 4, a counter-width function, and the command priority encoding used by both control and datapath.
REQ-029 The counter and K decode SHALL live in sub-module mult_bit_counter (ports: Clk, rst, clr, inc, K); the accumulator logic SHALL remain in mult_datapath.

Verification
REQ-030 The bench SHALL check: N=4, Mcand=13, Mplier=11, driven via the control sequence (Load; then per bit Ad if M, then Sh) -> Product=143, with K high only during the 4th Sh cycle.
REQ-031 The bench SHALL check: Mcand=15, Mplier=15 -> ACC[8] carry set after the 4th Ad, Product=225.
REQ-032 The bench SHALL check: Mcand=0 or Mplier=0 -> Product=0; M stays 0 throughout when Mplier=0.
REQ-033 The bench SHALL check: Load with Ad and Sh all asserted -> ACC = Mplier and counter = 0; the add and shift are ignored.
REQ-034 The bench SHALL check: rst=0 applied after 2 shifts of a 6*7 run -> next cycle Product=0, M=0, K=0; a new Load of 6*7 then yields 42.
REQ-035 The bench SHALL check, with MULT_LATCH_MCAND_EN defined: change Mcand from 5 to 9 after Load, with Mplier=3 -> Product=15 (without the macro: 27).

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier datapath: default width,
// counter sizing and the command priority encoding.
package mult_pkg;

    localparam int MULT_N_DEFAULT = 4;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LOAD      = 3'd1,
        CMD_ADD       = 3'd2,
        CMD_SHIFT     = 3'd3,
        CMD_ADD_SHIFT = 3'd4
    } mult_cmd_e;

    // A 1-bit counter is the floor so N=2 still has a legal vector width.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Load dominates; Ad/Sh only matter when no Load is present.
    function automatic mult_cmd_e decode_cmd(input logic load, input logic ad, input logic sh);
        mult_cmd_e cmd;
        if (load) begin
            cmd = CMD_LOAD;
        end else if (ad && sh) begin
            cmd = CMD_ADD_SHIFT;
        end else if (ad) begin
            cmd = CMD_ADD;
        end else if (sh) begin
            cmd = CMD_SHIFT;
        end else begin
            cmd = CMD_NONE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Shift counter for the multiplier; K flags that the next shift is the last one.
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic Clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic K
);

    localparam int W = cnt_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    // Explicit wrap at N-1 so non-power-of-two widths cycle correctly.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_cnt <= {W{1'b0}};
        end else if (clr) begin
            r_cnt <= {W{1'b0}};
        end else if (inc) begin
            r_cnt <= (r_cnt == LAST) ? {W{1'b0}} : r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign K = (r_cnt == LAST);

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: 2N+1-bit accumulator plus bit counter.
// Optional MULT_LATCH_MCAND_EN captures the multiplicand on Load.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic           Clk,
    input  logic           rst,
    input  logic           Load,
    input  logic           Ad,
    input  logic           Sh,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);

    logic [2*N:0] r_acc;
    logic [2*N:0] w_acc_next;
    logic [N:0]   w_sum;
    logic [N-1:0] w_mcand_eff;
    mult_cmd_e    w_cmd;
    logic         w_clr;
    logic         w_inc;

    assign w_cmd = decode_cmd(Load, Ad, Sh);
    assign w_clr = (w_cmd == CMD_LOAD);
    assign w_inc = (w_cmd == CMD_SHIFT) || (w_cmd == CMD_ADD_SHIFT);

`ifdef MULT_LATCH_MCAND_EN
    logic [N-1:0] r_mcand;

    // Multiplicand snapshot taken on Load; later port changes are ignored.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_mcand <= {N{1'b0}};
        end else if (w_cmd == CMD_LOAD) begin
            r_mcand <= Mcand;
        end else begin
            r_mcand <= r_mcand;
        end
    end

    assign w_mcand_eff = r_mcand;
`else
    assign w_mcand_eff = Mcand;
`endif

    assign w_sum = {1'b0, r_acc[2*N-1:N]} + {1'b0, w_mcand_eff};

    // Next accumulator value; add-and-shift shifts the fresh sum including its carry.
    always_comb begin
        w_acc_next = r_acc;
        case (w_cmd)
            CMD_LOAD:      w_acc_next = {{(N+1){1'b0}}, Mplier};
            CMD_ADD:       w_acc_next = {w_sum, r_acc[N-1:0]};
            CMD_SHIFT:     w_acc_next = {1'b0, r_acc[2*N:1]};
            CMD_ADD_SHIFT: w_acc_next = {1'b0, w_sum, r_acc[N-1:1]};
            default:       w_acc_next = r_acc;
        endcase
    end

    // Accumulator register; reset overrides any command.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_acc <= {(2*N+1){1'b0}};
        end else begin
            r_acc <= w_acc_next;
        end
    end

    mult_bit_counter #(.N(N)) u_cnt (
        .Clk (Clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_inc),
        .K   (K)
    );

    assign M       = r_acc[0];
    assign Product = r_acc[2*N-1:0];

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath (N=4): vector table driven through the
// Load / Ad-if-M / Sh control sequence, plus hand-written corner sequences.
module tb_mult_datapath;

    logic       Clk;
    logic       rst;
    logic       Load;
    logic       Ad;
    logic       Sh;
    logic [3:0] Mcand;
    logic [3:0] Mplier;
    logic       M;
    logic       K;
    logic [7:0] Product;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] mcand;
        logic [3:0] mplier;
        logic [7:0] product;
        bit         carry;
    } vec_t;

    vec_t vecs[8];

    mult_datapath #(.N(4)) dut (
        .Clk     (Clk),
        .rst     (rst),
        .Load    (Load),
        .Ad      (Ad),
        .Sh      (Sh),
        .Mcand   (Mcand),
        .Mplier  (Mplier),
        .M       (M),
        .K       (K),
        .Product (Product)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_mult(input logic [3:0] a, input logic [3:0] a_after,
                            input logic [3:0] b, input logic [7:0] exp, input bit carry);
        logic [7:0] want;
        Mcand = a;
        Mplier = b;
        Load = 1'b1;
        step();
        Load = 1'b0;
        Mcand = a_after;
        exp_q.push_back(exp);
        check("load_acc", {56'd0, Product}, {60'd0, b});
        for (int i = 0; i < 4; i++) begin
            check("m_bit", {63'd0, M}, {63'd0, b[i]});
            if (M) begin
                Ad = 1'b1;
                step();
                Ad = 1'b0;
                if (carry && i == 3) check("carry_bit8", {63'd0, dut.r_acc[8]}, 64'd1);
            end
            check("k_pending", {63'd0, K}, (i == 3) ? 64'd1 : 64'd0);
            Sh = 1'b1;
            step();
            Sh = 1'b0;
        end
        check("k_wrap", {63'd0, K}, 64'd0);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: queue empty, expected 1 pending entry");
        end else begin
            want = exp_q.pop_front();
            check("product", {56'd0, Product}, {56'd0, want});
        end
    endtask

    initial begin
        vecs[0] = '{4'd13, 4'd11, 8'd143, 1'b0};
        vecs[1] = '{4'd15, 4'd15, 8'd225, 1'b1};
        vecs[2] = '{4'd0,  4'd9,  8'd0,   1'b0};
        vecs[3] = '{4'd12, 4'd0,  8'd0,   1'b0};
        vecs[4] = '{4'd1,  4'd1,  8'd1,   1'b0};
        vecs[5] = '{4'd6,  4'd7,  8'd42,  1'b0};
        vecs[6] = '{4'd15, 4'd1,  8'd15,  1'b0};
        vecs[7] = '{4'd8,  4'd8,  8'd64,  1'b0};

        rst = 1'b0;
        Load = 1'b0;
        Ad = 1'b0;
        Sh = 1'b0;
        Mcand = 4'd0;
        Mplier = 4'd0;
        step();
        step();
        rst = 1'b1;
        check("reset_product", {56'd0, Product}, 64'd0);
        check("reset_m", {63'd0, M}, 64'd0);
        check("reset_k", {63'd0, K}, 64'd0);

        for (int v = 0; v < 8; v++) begin
            run_mult(vecs[v].mcand, vecs[v].mcand, vecs[v].mplier, vecs[v].product, vecs[v].carry);
        end

        // Shifting past completion keeps shifting the accumulator.
        Sh = 1'b1;
        step();
        Sh = 1'b0;
        check("extra_shift", {56'd0, Product}, 64'd32);
        check("extra_shift_k", {63'd0, K}, 64'd0);

        // Load with Ad and Sh asserted: only the load takes effect.
        Mcand = 4'd13;
        Mplier = 4'd11;
        Load = 1'b1;
        step();
        Load = 1'b0;
        Sh = 1'b1;
        step();
        step();
        Mcand = 4'd7;
        Mplier = 4'd9;
        Load = 1'b1;
        Ad = 1'b1;
        step();
        Load = 1'b0;
        Ad = 1'b0;
        Sh = 1'b0;
        check("prio_acc", {56'd0, Product}, 64'd9);
        check("prio_cnt", {62'd0, dut.u_cnt.r_cnt}, 64'd0);
        check("prio_k", {63'd0, K}, 64'd0);
        Sh = 1'b1;
        step();
        step();
        step();
        Sh = 1'b0;
        check("prio_k_after3", {63'd0, K}, 64'd1);
        check("prio_shifted", {56'd0, Product}, 64'd1);

        // Reset in the middle of a 6*7 run, with commands still asserted.
        Mcand = 4'd6;
        Mplier = 4'd7;
        Load = 1'b1;
        step();
        Load = 1'b0;
        Ad = 1'b1; step(); Ad = 1'b0;
        Sh = 1'b1; step(); Sh = 1'b0;
        Ad = 1'b1; step(); Ad = 1'b0;
        Sh = 1'b1; step(); Sh = 1'b0;
        rst = 1'b0;
        Ad = 1'b1;
        Sh = 1'b1;
        step();
        rst = 1'b1;
        Ad = 1'b0;
        Sh = 1'b0;
        check("midrst_product", {56'd0, Product}, 64'd0);
        check("midrst_m", {63'd0, M}, 64'd0);
        check("midrst_k", {63'd0, K}, 64'd0);
        run_mult(4'd6, 4'd6, 4'd7, 8'd42, 1'b0);

        // Multiplicand changes after Load.
`ifdef MULT_LATCH_MCAND_EN
        run_mult(4'd5, 4'd9, 4'd3, 8'd15, 1'b0);
`else
        run_mult(4'd5, 4'd9, 4'd3, 8'd27, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
